fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
- Sequencer for the single-precision FP32 divide path.
- Accepts two IEEE-754 binary32 operands over a valid/ready handshake.
- Unpacks the operands and resolves special cases without using the array.
- For ordinary operands, drives the external combinational non-restoring mantissa divider array, holding its inputs stable for a multicycle settle window, then samples quotient/remainder, packs the result and raises flags.
- Sits between the FPU operand issue logic and the result writeback.

Parameters:
- DIV_WAIT, 2: cycles divider inputs are held before quotient/remainder are sampled (legal ≥1; multicycle constraint on the array matches this value).
- CNT_W, 4: width of the settle counter (2^CNT_W > DIV_WAIT).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept.
- in_a  in  32  dividend (binary32).
- in_b  in  32  divisor (binary32).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  quotient (binary32).
- out_flags  out  5  {invalid, divzero, overflow, underflow, inexact}.
- div_dividend  out  24  to array: {1, frac_a}.
- div_divisor  out  24  to array: {1, frac_b}.
- div_ge  out  1  to array: mant_a ≥ mant_b.
- div_quotient  in  24  from array, normalized (bit 23 = 1 for legal operands).
- div_remainder  in  24  from array; nonzero means inexact.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE, counter 0, out_valid=0, out_result=0, out_flags=0, div_* outputs=0. Reset mid-operation aborts the operation; the partial result is discarded and in_ready=1 in the following cycle.
- in_ready=1 only in IDLE. A transfer occurs on an edge with in_valid&in_ready; operands are registered at that edge.

FSM:
- IDLE → UNPACK on a transfer.
- UNPACK (1 cycle):
  - Classify each operand as zero (exp=0; denormals are treated as zero, DAZ), inf, NaN, or normal.
  - Special case → DONE with the special result.
  - Otherwise load div_dividend, div_divisor and div_ge; exp_tmp = ea − eb + 127 − (div_ge ? 0 : 1), 10-bit signed; counter = 0 → DIV.
- DIV: div_* outputs held constant; counter increments each cycle; → PACK when counter == DIV_WAIT−1 (DIV lasts exactly DIV_WAIT cycles).
- PACK (1 cycle): sample div_quotient and div_remainder, then:
  - exp_tmp ≥ 255 → {s, 0x7F7FFFFF} (RTZ largest finite); overflow=1, inexact=1.
  - exp_tmp ≤ 0 → {s, 31'b0} (FTZ); underflow=1, inexact=1.
  - else {s, exp_tmp[7:0], div_quotient[22:0]}; inexact = |div_remainder.
  - → DONE.
- DONE: out_valid=1; out_result and out_flags held stable until out_ready. On out_valid&out_ready → IDLE, out_valid=0 next cycle.
- Rounding mode is round-toward-zero only. Sign s = sa ^ sb for all non-NaN results.
- Latency: normal op, out_valid rises DIV_WAIT+3 edges after the accept edge. Special op, out_valid rises 2 edges after the accept edge. Next accept is possible in the cycle after the output handshake; no overlap.

Special cases (priority order):
1. Either operand NaN → 0x7FC00000, invalid.
2. 0/0 or inf/inf → 0x7FC00000, invalid.
3. Finite nonzero / 0 → {s, 0x7F800000}, divzero.
4. inf / finite → {s, inf}, no flags.
5. 0 / nonzero or finite / inf → {s, 0}, no flags.

Other rules:
- in_valid while not IDLE is ignored and operands are not captured.
- out_ready while not DONE has no effect.

Test Plan:
- 0x40C00000 / 0x40400000 (6/3), DIV_WAIT=2, out_ready=1 → out_result=0x40000000, flags=0, out_valid exactly 5 edges after accept, div_ge=1 held 2 cycles.
- 0x3F800000 / 0x3FC00000 (1/1.5) → div_ge=0, out_result=0x3F2AAAAA, flags=00001.
- 0x3F800000 / 0x00000000 → 0x7F800000, flags=01000, out_valid 2 edges after accept; div_* untouched. 0x00000000/0x00000000 → 0x7FC00000, flags=10000. 0xFF800000/0x40000000 → 0xFF800000, flags=0.
- 0x7F000000 / 0x3E800000 → 0x7F7FFFFF, flags=00101. 0x00800000 / 0x4F000000 → 0x00000000, flags=00011.
- Back-pressure: out_ready=0 for 10 cycles in DONE → out_result and out_flags stable, in_ready=0, in_valid pulses ignored; then out_ready=1 → IDLE, next op accepted 1 cycle later.
- rst asserted during DIV → next cycle IDLE, out_valid=0, in_ready=1; a new 6/3 op completes correctly.

Source files
------------

// File: rtl/fp_div_seq.sv
// fp_div_seq -- sequencer for the single-precision (binary32) divide path.
//
// Takes an operand pair over a valid/ready handshake and unpacks both
// operands. Special cases (NaN, zero, infinity, and denormals, which are
// flushed to zero on input) are resolved directly. Ordinary operands drive
// an external combinational mantissa divider array. The array inputs are
// held for DIV_WAIT cycles before its quotient and remainder are sampled.
// The result is packed with round-toward-zero and flush-to-zero on
// underflow.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake; in_ready is high only when idle
//   in_a, in_b        dividend / divisor (binary32)
//   out_valid/out_ready result handshake; result is held until accepted
//   out_result        quotient (binary32)
//   out_flags         {invalid, divzero, overflow, underflow, inexact}
//   div_dividend      to array: {1, frac_a}
//   div_divisor       to array: {1, frac_b}
//   div_ge            to array: mant_a >= mant_b
//   div_quotient      from array: normalised quotient, bit 23 set
//   div_remainder     from array: nonzero means the quotient is inexact
module fp_div_seq #(
   parameter int DIV_WAIT = 2,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_flags,
   output logic [23:0] div_dividend,
   output logic [23:0] div_divisor,
   output logic        div_ge,
   input  logic [23:0] div_quotient,
   input  logic [23:0] div_remainder
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_DIV,
      ST_PACK,
      ST_DONE
   } state_t;

   localparam logic [31:0] QNAN = 32'h7FC00000;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [31:0]        a_reg, a_next;
   logic [31:0]        b_reg, b_next;
   logic signed [9:0]  exp_reg, exp_next;
   logic [23:0]        dividend_reg, dividend_next;
   logic [23:0]        divisor_reg, divisor_next;
   logic               ge_reg, ge_next;
   logic [31:0]        result_reg, result_next;
   logic [4:0]         flags_reg, flags_next;

   // Operand fields and classification (denormals count as zero)
   logic [7:0]         ea, eb;
   logic [22:0]        fa, fb;
   logic               sign;
   logic               a_zero, a_inf, a_nan;
   logic               b_zero, b_inf, b_nan;
   logic [23:0]        mant_a, mant_b;
   logic               mant_ge;
   logic signed [9:0]  exp_calc;
   logic               special;
   logic [31:0]        special_result;
   logic [4:0]         special_flags;

   // The array guarantees a normalised quotient, so its MSB carries no
   // information beyond "operands were legal".
   logic               quot_msb_unused;
   assign quot_msb_unused = div_quotient[23];

   assign ea     = a_reg[30:23];
   assign eb     = b_reg[30:23];
   assign fa     = a_reg[22:0];
   assign fb     = b_reg[22:0];
   assign sign   = a_reg[31] ^ b_reg[31];
   assign a_zero = (ea == 8'd0);
   assign b_zero = (eb == 8'd0);
   assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
   assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
   assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
   assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
   assign mant_a = {1'b1, fa};
   assign mant_b = {1'b1, fb};
   assign mant_ge = (mant_a >= mant_b);

   // When mant_a < mant_b the array shifts the dividend one place further
   // to keep the quotient normalised, so the exponent drops by one.
   assign exp_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
                     - (mant_ge ? 10'sd0 : 10'sd1);

   // Special-case resolution, highest priority first
   always_comb begin
      special        = 1'b1;
      special_result = 32'd0;
      special_flags  = 5'b00000;
      if (a_nan || b_nan) begin
         special_result = QNAN;
         special_flags  = 5'b10000;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         special_result = QNAN;
         special_flags  = 5'b10000;
      end else if (b_zero && !a_inf) begin
         special_result = {sign, 31'h7F800000};
         special_flags  = 5'b01000;
      end else if (a_inf) begin
         special_result = {sign, 31'h7F800000};
      end else if (a_zero || b_inf) begin
         special_result = {sign, 31'h00000000};
      end else begin
         special = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      a_next        = a_reg;
      b_next        = b_reg;
      exp_next      = exp_reg;
      dividend_next = dividend_reg;
      divisor_next  = divisor_reg;
      ge_next       = ge_reg;
      result_next   = result_reg;
      flags_next    = flags_reg;
      case (state_reg)
         ST_IDLE: begin
            if (in_valid) begin
               a_next     = in_a;
               b_next     = in_b;
               state_next = ST_UNPACK;
            end
         end
         ST_UNPACK: begin
            if (special) begin
               result_next = special_result;
               flags_next  = special_flags;
               state_next  = ST_DONE;
            end else begin
               dividend_next = mant_a;
               divisor_next  = mant_b;
               ge_next       = mant_ge;
               exp_next      = exp_calc;
               cnt_next      = '0;
               state_next    = ST_DIV;
            end
         end
         ST_DIV: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(DIV_WAIT - 1)) begin
               state_next = ST_PACK;
            end
         end
         ST_PACK: begin
            if (exp_reg >= 10'sd255) begin
               result_next = {sign, 31'h7F7FFFFF};
               flags_next  = 5'b00101;
            end else if (exp_reg <= 10'sd0) begin
               result_next = {sign, 31'h00000000};
               flags_next  = 5'b00011;
            end else begin
               result_next = {sign, exp_reg[7:0], div_quotient[22:0]};
               flags_next  = {4'b0000, |div_remainder};
            end
            state_next = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg      <= '0;
         a_reg        <= 32'd0;
         b_reg        <= 32'd0;
         exp_reg      <= 10'sd0;
         dividend_reg <= 24'd0;
         divisor_reg  <= 24'd0;
         ge_reg       <= 1'b0;
         result_reg   <= 32'd0;
         flags_reg    <= 5'd0;
      end else begin
         cnt_reg      <= cnt_next;
         a_reg        <= a_next;
         b_reg        <= b_next;
         exp_reg      <= exp_next;
         dividend_reg <= dividend_next;
         divisor_reg  <= divisor_next;
         ge_reg       <= ge_next;
         result_reg   <= result_next;
         flags_reg    <= flags_next;
      end
   end

   assign in_ready     = (state_reg == ST_IDLE);
   assign out_valid    = (state_reg == ST_DONE);
   assign out_result   = result_reg;
   assign out_flags    = flags_reg;
   assign div_dividend = dividend_reg;
   assign div_divisor  = divisor_reg;
   assign div_ge       = ge_reg;

endmodule

// File: tb/tb_fp_div_seq.sv
// Testbench for fp_div_seq: models the external mantissa divider array,
// runs directed and random binary32 divisions and compares them against an
// arithmetic reference model.
module tb_fp_div_seq;

   localparam int DIV_WAIT = 2;
   localparam int CNT_W    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a, in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_flags;
   logic [23:0] div_dividend, div_divisor;
   logic        div_ge;
   logic [23:0] div_quotient, div_remainder;

   int total = 0;
   int bad   = 0;

   // Divider-array values the bench expects to see.
   logic [23:0] exp_dd = 24'd0;
   logic [23:0] exp_dv = 24'd0;
   logic        exp_g  = 1'b0;

   always #5 clk = ~clk;

   fp_div_seq #(.DIV_WAIT(DIV_WAIT), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_a          (in_a),
      .in_b          (in_b),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_flags     (out_flags),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_ge        (div_ge),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder)
   );

   // Combinational divider array: normalised mantissa quotient.
   logic [47:0] arr_num, arr_q, arr_r;
   always_comb begin
      arr_num = div_ge ? ({24'd0, div_dividend} << 23) : ({24'd0, div_dividend} << 24);
      arr_q   = 48'd0;
      arr_r   = 48'd0;
      if (div_divisor != 24'd0) begin
         arr_q = arr_num / {24'd0, div_divisor};
         arr_r = arr_num % {24'd0, div_divisor};
      end
   end
   assign div_quotient  = arr_q[23:0];
   assign div_remainder = arr_r[23:0];

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: exact integer quotient, then RTZ / FTZ / overflow rules.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [4:0] f, output bit sp);
      int          ea, eb, e;
      logic [22:0] fa, fb;
      logic        s, inex;
      logic [47:0] num, q, rem, mant;
      bit          az, ai, an, bz, bi, bn;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      fa = a[22:0];
      fb = b[22:0];
      s  = a[31] ^ b[31];
      az = (ea == 0);
      bz = (eb == 0);
      ai = (ea == 255) && (fa == 0);
      bi = (eb == 255) && (fb == 0);
      an = (ea == 255) && (fa != 0);
      bn = (eb == 255) && (fb != 0);
      sp = 1;
      f  = 5'b00000;
      r  = 32'd0;
      if (an || bn || (az && bz) || (ai && bi)) begin
         r = 32'h7FC00000;
         f = 5'b10000;
      end else if (bz && !ai) begin
         r = {s, 31'h7F800000};
         f = 5'b01000;
      end else if (ai) begin
         r = {s, 31'h7F800000};
      end else if (az || bi) begin
         r = {s, 31'h00000000};
      end else begin
         sp  = 0;
         num = {1'b1, fa, 24'd0};
         q   = num / {24'd0, 1'b1, fb};
         rem = num % {24'd0, 1'b1, fb};
         if (q >= 48'h1000000) begin
            e    = ea - eb + 127;
            mant = q >> 1;
            inex = (rem != 0) || q[0];
         end else begin
            e    = ea - eb + 126;
            mant = q;
            inex = (rem != 0);
         end
         if (e >= 255) begin
            r = {s, 31'h7F7FFFFF};
            f = 5'b00101;
         end else if (e <= 0) begin
            r = {s, 31'h00000000};
            f = 5'b00011;
         end else begin
            r = {s, 8'(e), mant[22:0]};
            f = {4'b0000, inex};
         end
      end
   endtask

   // One transaction; called at posedge+1 with the sequencer idle. hold is
   // the number of cycles out_ready stays low in DONE; poke pulses in_valid
   // during that time.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit poke);
      logic [31:0] er;
      logic [4:0]  ef;
      bit          sp;
      int          lat;
      ref_div(a, b, er, ef, sp);
      if (!sp) begin
         exp_dd = {1'b1, a[22:0]};
         exp_dv = {1'b1, b[22:0]};
         exp_g  = ({1'b1, a[22:0]} >= {1'b1, b[22:0]});
      end
      chk_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (!out_valid) begin
            chk_eq("div_dividend", {8'd0, div_dividend}, {8'd0, exp_dd});
            chk_eq("div_divisor", {8'd0, div_divisor}, {8'd0, exp_dv});
            chk_eq("div_ge", {31'd0, div_ge}, {31'd0, exp_g});
         end
      end
      chk_eq("out_valid", {31'd0, out_valid}, 32'd1);
      chk_eq("latency", lat, sp ? 32'd2 : 32'(DIV_WAIT + 3));
      chk_eq("result", out_result, er);
      chk_eq("flags", {27'd0, out_flags}, {27'd0, ef});
      chk_eq("div_dividend_kept", {8'd0, div_dividend}, {8'd0, exp_dd});
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            in_a     = $urandom;
            in_b     = $urandom;
            in_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk_eq("hold_valid", {31'd0, out_valid}, 32'd1);
         chk_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk_eq("hold_result", out_result, er);
         chk_eq("hold_flags", {27'd0, out_flags}, {27'd0, ef});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk_eq("valid_drop", {31'd0, out_valid}, 32'd0);
      chk_eq("in_ready_back", {31'd0, in_ready}, 32'd1);
      $display("op a=%h b=%h result=%h flags=%b exp=%h/%b latency=%0d",
               a, b, out_result, out_flags, er, ef, lat);
   endtask

   function automatic logic [31:0] rand_fp();
      int          sel;
      logic [7:0]  e;
      logic [22:0] f;
      sel = $urandom_range(0, 15);
      f   = 23'($urandom);
      if (sel == 0) begin
         e = 8'd0;
         if ($urandom_range(0, 1) == 0) f = 23'd0;
      end else if (sel == 1) begin
         e = 8'hFF;
         if ($urandom_range(0, 1) == 0) f = 23'd0;
      end else if (sel == 2) begin
         e = 8'($urandom_range(235, 254));
      end else if (sel == 3) begin
         e = 8'($urandom_range(1, 20));
      end else begin
         e = 8'($urandom_range(100, 154));
      end
      return {1'($urandom), e, f};
   endfunction

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 32'd0;
      in_b      = 32'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk_eq("rst_result", out_result, 32'd0);
      chk_eq("rst_flags", {27'd0, out_flags}, 32'd0);
      chk_eq("rst_dividend", {8'd0, div_dividend}, 32'd0);
      chk_eq("rst_divisor", {8'd0, div_divisor}, 32'd0);
      chk_eq("rst_ge", {31'd0, div_ge}, 32'd0);
      rst = 1'b0;

      // Directed cases
      run_op(32'h40C00000, 32'h40400000, 0, 0);   // 6/3
      run_op(32'h3F800000, 32'h3FC00000, 0, 0);   // 1/1.5
      run_op(32'h3F800000, 32'h00000000, 0, 0);   // divzero
      run_op(32'h00000000, 32'h00000000, 0, 0);   // 0/0
      run_op(32'hFF800000, 32'h40000000, 0, 0);   // -inf/2
      run_op(32'h7F000000, 32'h3E800000, 0, 0);   // overflow
      run_op(32'h00800000, 32'h4F000000, 0, 0);   // underflow
      run_op(32'h7F800000, 32'h00000000, 0, 0);   // inf/0
      run_op(32'h7FC00001, 32'h3F800000, 0, 0);   // NaN operand
      run_op(32'h00400000, 32'h3F800000, 0, 0);   // denormal dividend -> 0

      // Back-pressure with ignored in_valid pulses, then immediate next op
      run_op(32'h40C00000, 32'h40400000, 10, 1);
      run_op(32'h3F800000, 32'h3FC00000, 0, 0);

      // Reset during DIV aborts the operation
      in_a     = 32'h40C00000;
      in_b     = 32'h40400000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_eq("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk_eq("abort_result", out_result, 32'd0);
      chk_eq("abort_dividend", {8'd0, div_dividend}, 32'd0);
      exp_dd = 24'd0;
      exp_dv = 24'd0;
      exp_g  = 1'b0;
      run_op(32'h40C00000, 32'h40400000, 0, 0);

      // Random operands
      for (int n = 0; n < 150; n++) begin
         run_op(rand_fp(), rand_fp(), $urandom_range(0, 2), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
